keypad_scan: RTL
================

Name: keypad_scan

Overview:
- Input-side counterpart to the scanned 7-segment display path. The display scans digit enables outward; this block scans a 4x4 key matrix inward.
- It drives one-hot active-low columns, samples active-low rows, debounces, and emits one key event per physical press.
- Calculator entry logic downstream consumes key_code/key_valid to build operands a, b and opcode k.

Parameters:
- SCAN_DIV, 5000, clk cycles per scan tick; same refresh rate as the display scan.
- DEBOUNCE_CNT, 4, consecutive matching ticks required to accept a press or a release (range 1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row_in  input  4  matrix rows, active-low, externally pulled up, asynchronous to clk
- col_out  output  4  matrix column drive, active-low one-hot
- key_code  output  4  last accepted key, row*4+col (0..15)
- key_valid  output  1  single-cycle pulse when a new key is accepted
- key_held  output  1  high while the accepted key remains pressed

Behaviour:
- Reset (rst_n low, any time, takes effect immediately):
  - col_out=4'b1110, key_code=0, key_valid=0, key_held=0.
  - state=SCAN, column index=0, divider=0, debounce/release counters=0, synchronizer flops=4'b1111.
  - A press in progress when reset asserts is discarded; no key_valid follows deassertion until a full debounce completes.
- Synchronizer: row_in passes through 2 flops; only the synchronized value (rs) is used.
- Divider: counts 0..SCAN_DIV-1 and wraps. tick is high for one cycle when count==SCAN_DIV-1. All FSM decisions occur only on tick cycles.
- Row classification of rs: NONE=4'b1111; SINGLE=exactly one bit low; MULTI=two or more low.
- SCAN:
  - col_out=~(1<<col).
  - On tick with SINGLE: capture row index and current col as candidate, debounce cnt=1, go DEBOUNCE. If DEBOUNCE_CNT==1, accept immediately as in DEBOUNCE.
  - On tick with NONE or MULTI: col=(col+1) mod 4 (3 wraps to 0).
- DEBOUNCE:
  - Column frozen.
  - On tick with the same SINGLE row: cnt++. When cnt reaches DEBOUNCE_CNT, on the next cycle: key_code={row,col}, key_valid=1 for exactly one cycle, key_held=1, go PRESSED.
  - On tick with any other pattern: back to SCAN, advance col, no event.
- PRESSED:
  - Column frozen; key_held=1.
  - On tick with NONE: release cnt++. Any non-NONE sample clears release cnt to 0.
  - When release cnt reaches DEBOUNCE_CNT: key_held=0, go SCAN, advance col.
  - No key_valid while in PRESSED. A second key pressed meanwhile is ignored, and its activity delays release.
- key_code holds its value from key_valid until the next key_valid; never changes otherwise.
- Latency: a clean press seen at rs on a SCAN tick gives key_valid (DEBOUNCE_CNT-1) ticks later plus 1 cycle.
- Only the four one-hot patterns ever appear on col_out.

Test Plan (sim with SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset, rows idle -> col_out cycles 1110,1101,1011,0111,1110 changing every 4 clks; key_valid never asserts.
- Hold key row2/col1 (row_in=4'b1011 only while col_out=4'b1101) for 20 ticks -> exactly one key_valid pulse, key_code=4'd9, key_held=1. After release, key_held falls 3 ticks later and scanning resumes at col2.
- Bounce: row low for 1 tick, high for 1, low steady -> no pulse during the bounce; one pulse with key_code correct after 3 stable ticks.
- Two rows low in the same column (row_in=4'b1001 on col 0) -> treated as MULTI: no key_valid, col keeps advancing.
- During PRESSED of key 0, press and release key 5 -> no second key_valid; key_code stays 0; release count restarts on each non-idle sample.
- Assert rst_n low mid-DEBOUNCE (cnt=2) then release with key still held -> outputs at reset values immediately; a fresh 3-tick debounce precedes the single key_valid.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 key matrix scanner with debounce.
//   Drives one active-low column at a time, samples the active-low rows through
//   a 2-flop synchronizer, and only makes decisions on a slow scan tick. A key
//   is accepted after DEBOUNCE_CNT matching ticks and released after
//   DEBOUNCE_CNT idle ticks.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row_in     matrix rows, active-low, asynchronous to clk
//   col_out    column drive, active-low one-hot
//   key_code   last accepted key, row*4+col
//   key_valid  one-cycle pulse per accepted press
//   key_held   high while the accepted key is still down
module keypad_scan #(
  parameter int SCAN_DIV     = 5000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] DB_N = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      cand_q, cand_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      rel_q, rel_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic [3:0]      r1_q, rs_q;

  logic            tick;
  logic            is_none, is_single;
  logic [2:0]      nlow;
  logic [1:0]      row_idx;

  // Row synchronizer; idle (all high) out of reset so no phantom press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_q <= 4'hF;
      rs_q <= 4'hF;
    end else begin
      r1_q <= row_in;
      rs_q <= r1_q;
    end
  end

  assign tick  = (div_q == DW'(SCAN_DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Row classification: count low rows, pick the index of the low one.
  always_comb begin
    nlow    = '0;
    row_idx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs_q[i]) begin
        nlow    = nlow + 3'd1;
        row_idx = 2'(i);
      end
    end
  end

  assign is_none   = (rs_q == 4'hF);
  assign is_single = (nlow == 3'd1);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (is_single) begin
            cand_d = row_idx;
            if (DB_N <= 4'd1) begin
              code_d  = {row_idx, col_q};
              valid_d = 1'b1;
              rel_d   = '0;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              cnt_d   = 4'd1;
              state_d = DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (is_single && row_idx == cand_q) begin
            if (cnt_q + 4'd1 >= DB_N) begin
              // Registered outputs make the event appear one cycle after this tick.
              code_d  = {cand_q, col_q};
              valid_d = 1'b1;
              rel_d   = '0;
              cnt_d   = '0;
              state_d = PRESSED;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
        PRESSED: begin
          // Any activity on the frozen column, even another key, restarts release.
          if (is_none) begin
            if (rel_q + 4'd1 >= DB_N) begin
              rel_d   = '0;
              col_d   = col_q + 2'd1;
              state_d = SCAN;
            end else begin
              rel_d = rel_q + 4'd1;
            end
          end else begin
            rel_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SCAN;
      div_q   <= '0;
      col_q   <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      rel_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      col_q   <= col_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = (state_q == PRESSED);

endmodule
